// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional overflow / divide-by-zero pre-check enabled by defining DIVIDER_OVF_CHECK_EN.
module shift_sub_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           st_i,
  input  logic [2*N-1:0] dividend_i,
  input  logic [N-1:0]   divisor_i,
  output logic [N-1:0]   quo_o,
  output logic [N-1:0]   rem_o,
  output logic           ovf_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CHK,
    DIV,
    DONE
  } state_t;

  state_t         state, state_nx;
  logic [N:0]     r_q, r_nx;
  logic [N-1:0]   q_q, q_nx;
  logic [N-1:0]   d_q, d_nx;
  logic [CW-1:0]  cnt_q, cnt_nx;
  logic [N-1:0]   quo_nx, rem_nx;
  logic           ovf_nx;

  logic [N:0]     t_shift;
  logic [N:0]     t_diff;
  logic           sub_ok;

  // T is the upper half of {R,Q} << 1; a set R[N] would have pushed T past any divisor.
  assign t_shift = {r_q[N-1:0], q_q[N-1]};
  assign t_diff  = t_shift - {1'b0, d_q};
  assign sub_ok  = r_q[N] | (t_shift >= {1'b0, d_q});

`ifdef DIVIDER_OVF_CHECK_EN
  logic ovf_det;
  // A high half not below the divisor cannot yield an N-bit quotient; D=0 falls out too.
  assign ovf_det = (r_q[N-1:0] >= d_q);
`endif

  // NOTE: every *_nx signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nx = state;
    r_nx     = r_q;
    q_nx     = q_q;
    d_nx     = d_q;
    cnt_nx   = cnt_q;
    quo_nx   = quo_o;
    rem_nx   = rem_o;
    ovf_nx   = ovf_o;

    case (state)
      IDLE: begin
        if (st_i) begin
          r_nx     = {1'b0, dividend_i[2*N-1:N]};
          q_nx     = dividend_i[N-1:0];
          d_nx     = divisor_i;
          state_nx = CHK;
        end
      end

      CHK: begin
        cnt_nx   = '0;
        state_nx = DIV;
`ifdef DIVIDER_OVF_CHECK_EN
        if (ovf_det) begin
          quo_nx   = '0;
          rem_nx   = '0;
          ovf_nx   = 1'b1;
          state_nx = DONE;
        end
`endif
      end

      DIV: begin
        r_nx   = sub_ok ? t_diff : t_shift;
        q_nx   = {q_q[N-2:0], sub_ok};
        cnt_nx = cnt_q + 1'b1;
        // Results are captured on the edge that enters DONE, including the final bit.
        if (cnt_q == LAST_CNT) begin
          quo_nx   = q_nx;
          rem_nx   = r_nx[N-1:0];
          ovf_nx   = 1'b0;
          state_nx = DONE;
        end
      end

      DONE: state_nx = IDLE;

      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      quo_o <= '0;
      rem_o <= '0;
      ovf_o <= 1'b0;
    end else begin
      state <= state_nx;
      r_q   <= r_nx;
      q_q   <= q_nx;
      d_q   <= d_nx;
      cnt_q <= cnt_nx;
      quo_o <= quo_nx;
      rem_o <= rem_nx;
      ovf_o <= ovf_nx;
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

endmodule
